// File: rtl/counter_sched_pkg.sv
// -----------------------------------------------------------------------------
// counter_sched_pkg
// Shared types and helpers for the counter_sched interval scheduler.
//   - state_e   : controller states (IDLE, RUN, DONE)
//   - CNT_W_DEF : default counter / duration width
//   - N_REQ_DEF : default number of requesters
//   - rr_next() : round-robin successor index, wraps at n
// Optional feature macro used by the top level: CNT_SCHED_ABORT_EN.
// -----------------------------------------------------------------------------
package counter_sched_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int N_REQ_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index that follows idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/interval_counter.sv
// -----------------------------------------------------------------------------
// interval_counter
// Elapsed-cycle counter shared by all requesters. Synchronous clear has
// priority over increment; asynchronous active-low reset forces zero.
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset
//   clr   in   synchronous clear to zero
//   en    in   increment by one this cycle
//   count out  current count (registered)
// -----------------------------------------------------------------------------
module interval_counter
  import counter_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sched.sv
// -----------------------------------------------------------------------------
// counter_sched
// Round-robin scheduler that lends one interval counter to N_REQ clients.
// The winner's duration is latched at grant; the counter runs for that many
// cycles, then a one-cycle done pulse is sent to the winner.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req          per-client request, held until its done pulse
//   dur          per-client duration, slice i = dur[i*CNT_W +: CNT_W]
//   gnt          one-hot grant (registered), zero when idle
//   done         one-cycle completion pulse (registered)
//   busy         high whenever the controller is not idle (registered)
//   cnt_en       counter enable, high in RUN only (registered)
//   cnt_value    elapsed cycles of the current interval
// Optional macro: CNT_SCHED_ABORT_EN -- when defined, a granted client that
// drops req during RUN aborts its interval (no done, pointer advances).
// -----------------------------------------------------------------------------
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] dur,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   cnt_en,
  output logic [CNT_W-1:0]       cnt_value
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win_q;
  logic [CNT_W-1:0] len_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic             busy_q;
  logic             cnt_en_q;

  logic             found_s;
  logic [PTR_W-1:0] win_s;
  logic [PTR_W:0]   idx_s;
  logic [CNT_W-1:0] dur_win_s;
  logic [N_REQ-1:0] onehot_s;
  logic             abort_s;
  logic             last_s;
  logic             clr_s;
  logic             en_s;

  // Round-robin search: first asserted req starting at ptr, wrapping at N_REQ.
  always_comb begin
    found_s = 1'b0;
    win_s   = ptr_q;
    idx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (idx_s >= (PTR_W+1)'(N_REQ)) begin
        idx_s = idx_s - (PTR_W+1)'(N_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s[PTR_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[PTR_W-1:0];
      end else begin
        found_s = found_s;
        win_s   = win_s;
      end
    end
  end

  assign dur_win_s = dur[win_s*CNT_W +: CNT_W];
  assign onehot_s  = N_REQ'(1) << win_s;

`ifdef CNT_SCHED_ABORT_EN
  // Granted client released its request before the interval finished.
  assign abort_s = (state_q == ST_RUN) && !(|(req & gnt_q));
`else
  assign abort_s = 1'b0;
`endif

  // Final RUN cycle: this edge brings cnt_value up to len (never past it).
  assign last_s = (state_q == ST_RUN) && ((cnt_value + CNT_W'(1)) == len_q);
  assign clr_s  = ((state_q == ST_IDLE) && found_s) || (state_q == ST_DONE) || abort_s;
  assign en_s   = (state_q == ST_RUN) && !abort_s;

  interval_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .en    (en_s),
    .count (cnt_value)
  );

  // Controller FSM with pointer, latched length and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      len_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cnt_en_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found_s) begin
            gnt_q  <= onehot_s;
            win_q  <= win_s;
            len_q  <= dur_win_s;
            busy_q <= 1'b1;
            if (dur_win_s == '0) begin
              state_q  <= ST_DONE;
              done_q   <= onehot_s;
              cnt_en_q <= 1'b0;
            end else begin
              state_q  <= ST_RUN;
              done_q   <= '0;
              cnt_en_q <= 1'b1;
            end
          end else begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            cnt_en_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort_s) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            cnt_en_q <= 1'b0;
            ptr_q    <= PTR_W'(rr_next(int'(win_q), N_REQ));
          end else if (last_s) begin
            state_q  <= ST_DONE;
            done_q   <= gnt_q;
            cnt_en_q <= 1'b0;
          end else begin
            state_q  <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          gnt_q    <= '0;
          done_q   <= '0;
          busy_q   <= 1'b0;
          cnt_en_q <= 1'b0;
          ptr_q    <= PTR_W'(rr_next(int'(win_q), N_REQ));
        end
        default: begin
          state_q  <= ST_IDLE;
          gnt_q    <= '0;
          done_q   <= '0;
          busy_q   <= 1'b0;
          cnt_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign cnt_en = cnt_en_q;

endmodule
